// File: rtl/iq_txd_serializer_if.sv
// AXI-Stream word channel feeding the IQ symbol serializer.
// Signals:
//   tdata  [31:0] word, sent MSB symbol first
//   tvalid        upstream word valid
//   tlast         last word of a frame
//   tready        serializer accepts the word at this edge
// master: upstream word source; slave: the serializer.
interface iq_txd_serializer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/iq_txd_serializer.sv
// Symbol serializer for the clk32 side of the IQ transmit path.
// Turns 32-bit stream words into 2-bit line symbols, one per clock, framed
// by an alternating preamble and a trailing idle gap. A word that is missing
// mid-frame raises an underrun pulse and the remainder of that frame is
// drained and discarded.
// Ports:
//   clk32       symbol clock
//   reset       asynchronous, active-high
//   s_axis      word stream (slave side); tready depends on state only
//   iq_txd      registered line symbol
//   tx_active   registered, high while preamble or data is on the line
//   frame_done  one-cycle pulse on normal frame completion
//   underrun    one-cycle pulse when a word is missing at a load point
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line at 00, waiting for a word to show up
// PREAMBLE  | sending 01/10 alternating; last symbol is a load point
// DATA      | shifting a word out; symbol 15 is a load point unless last
// FLUSH     | underrun recovery, swallow words up to and including tlast
// GAP       | post-frame idle symbols
module iq_txd_serializer #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_LEN      = 4
) (
  input  logic                       clk32,
  input  logic                       reset,
  iq_txd_serializer_if.slave         s_axis,
  output logic [1:0]                 iq_txd,
  output logic                       tx_active,
  output logic                       frame_done,
  output logic                       underrun
);

  localparam int PW = $clog2(PREAMBLE_LEN);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_FLUSH,
    ST_GAP
  } state_t;

  state_t          state;
  logic [31:0]     shreg;
  logic [3:0]      sym_cnt;
  logic [PW-1:0]   pre_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            last_f;
  logic            load_pt;

  // The two places a new word is taken: the final preamble symbol and the
  // final symbol of a non-last word. Keeping tready off tvalid avoids a
  // combinational path back into the upstream CDC FIFO.
  assign load_pt = ((state == ST_PREAMBLE) && (pre_cnt == PRE_LAST)) ||
                   ((state == ST_DATA) && (sym_cnt == 4'd15) && !last_f);

  assign s_axis.tready = load_pt || (state == ST_FLUSH);

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      sym_cnt    <= '0;
      pre_cnt    <= '0;
      gap_cnt    <= '0;
      last_f     <= 1'b0;
      iq_txd     <= 2'b00;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      if (load_pt) begin
        if (s_axis.tvalid) begin
          // Symbol 0 goes straight to the line; shreg holds symbols 1..15.
          iq_txd    <= s_axis.tdata[31:30];
          shreg     <= {s_axis.tdata[29:0], 2'b00};
          last_f    <= s_axis.tlast;
          sym_cnt   <= 4'd0;
          state     <= ST_DATA;
          tx_active <= 1'b1;
        end else begin
          underrun  <= 1'b1;
          iq_txd    <= 2'b00;
          state     <= ST_FLUSH;
          tx_active <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            iq_txd <= 2'b00;
            if (s_axis.tvalid) begin
              state     <= ST_PREAMBLE;
              pre_cnt   <= '0;
              iq_txd    <= 2'b01;
              tx_active <= 1'b1;
            end
          end
          ST_PREAMBLE: begin
            // Next symbol is for count p+1: 10 when p is even, 01 when odd.
            pre_cnt <= pre_cnt + PW'(1);
            iq_txd  <= pre_cnt[0] ? 2'b01 : 2'b10;
          end
          ST_DATA: begin
            if (sym_cnt != 4'd15) begin
              iq_txd  <= shreg[31:30];
              shreg   <= {shreg[29:0], 2'b00};
              sym_cnt <= sym_cnt + 4'd1;
            end else begin
              // Symbol 15 of the last word: frame ends normally.
              state      <= ST_GAP;
              gap_cnt    <= '0;
              iq_txd     <= 2'b00;
              frame_done <= 1'b1;
              tx_active  <= 1'b0;
            end
          end
          ST_FLUSH: begin
            iq_txd <= 2'b00;
            if (s_axis.tvalid && s_axis.tlast) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end
          ST_GAP: begin
            iq_txd <= 2'b00;
            if (gap_cnt == GAP_LAST) begin
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          default: begin
            state     <= ST_IDLE;
            iq_txd    <= 2'b00;
            tx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iq_txd_serializer.sv
module tb_iq_txd_serializer;
  logic clk32 = 1'b0;
  logic reset = 1'b1;
  always #5 clk32 = ~clk32;

  iq_txd_serializer_if ax0 ();
  iq_txd_serializer_if ax1 ();

  logic [1:0] txd0, txd1;
  logic act0, act1, fd0, fd1, ur0, ur1;

  iq_txd_serializer u0 (
    .clk32(clk32), .reset(reset), .s_axis(ax0), .iq_txd(txd0),
    .tx_active(act0), .frame_done(fd0), .underrun(ur0)
  );

  iq_txd_serializer #(.PREAMBLE_LEN(2), .GAP_LEN(1)) u1 (
    .clk32(clk32), .reset(reset), .s_axis(ax1), .iq_txd(txd1),
    .tx_active(act1), .frame_done(fd1), .underrun(ur1)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk32) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // scoreboard queues
  logic [1:0] q_sym0[$];
  logic [1:0] q_evt0[$];   // {frame_done, underrun}
  logic [1:0] q_sym1[$];

  int hi_run0, lo_run0, last_hi0, last_lo0, rdy_cnt0;
  bit prev_act0;
  int hi_run1, lo_run1, last_hi1, last_lo1, fd_cnt1;
  bit prev_act1;

  // monitor for the default-parameter instance
  always @(negedge clk32) begin
    if (reset) begin
      hi_run0 = 0; lo_run0 = 0; prev_act0 = 1'b0;
    end else begin
      if (act0) begin
        if (q_sym0.size() == 0) chk("u0_sym_extra", q_sym0.size(), 1);
        else chk("u0_sym", {30'd0, txd0}, {30'd0, q_sym0.pop_front()});
        if (!prev_act0) begin last_lo0 = lo_run0; hi_run0 = 0; end
        hi_run0++;
      end else begin
        chk("u0_idle_zero", {30'd0, txd0}, 0);
        if (prev_act0) begin last_hi0 = hi_run0; lo_run0 = 0; end
        lo_run0++;
      end
      prev_act0 = act0;
      if (fd0 || ur0) begin
        if (q_evt0.size() == 0) chk("u0_evt_extra", q_evt0.size(), 1);
        else chk("u0_evt", {30'd0, fd0, ur0}, {30'd0, q_evt0.pop_front()});
      end
      if (ax0.tready) rdy_cnt0++;
    end
  end

  // monitor for the short-preamble / short-gap instance
  always @(negedge clk32) begin
    if (reset) begin
      hi_run1 = 0; lo_run1 = 0; prev_act1 = 1'b0;
    end else begin
      if (act1) begin
        if (q_sym1.size() == 0) chk("u1_sym_extra", q_sym1.size(), 1);
        else chk("u1_sym", {30'd0, txd1}, {30'd0, q_sym1.pop_front()});
        if (!prev_act1) begin last_lo1 = lo_run1; hi_run1 = 0; end
        hi_run1++;
      end else begin
        chk("u1_idle_zero", {30'd0, txd1}, 0);
        if (prev_act1) begin last_hi1 = hi_run1; lo_run1 = 0; end
        lo_run1++;
      end
      prev_act1 = act1;
      if (ur1) chk("u1_no_underrun", {31'd0, ur1}, 0);
      if (fd1) fd_cnt1++;
    end
  end

  task automatic push_word(input logic [31:0] w, input bit which);
    for (int k = 0; k < 16; k++) begin
      if (which) q_sym1.push_back(w[31-2*k -: 2]);
      else q_sym0.push_back(w[31-2*k -: 2]);
    end
  endtask

  task automatic push_pre(input int len, input bit which);
    for (int p = 0; p < len; p++) begin
      if (which) q_sym1.push_back((p % 2 == 0) ? 2'b01 : 2'b10);
      else q_sym0.push_back((p % 2 == 0) ? 2'b01 : 2'b10);
    end
  endtask

  task automatic wait_hs0();
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk32);
      if (ax0.tready) got = 1'b1;
    end
    chk("u0_hs_timeout", {31'd0, got}, 1);
  endtask

  task automatic wait_hs1();
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk32);
      if (ax1.tready) got = 1'b1;
    end
    chk("u1_hs_timeout", {31'd0, got}, 1);
  endtask

  task automatic drain0(input int tail);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk32);
      done = (q_sym0.size() == 0) && (q_evt0.size() == 0);
    end
    chk("u0_drain", {31'd0, done}, 1);
    repeat (tail) @(negedge clk32);
  endtask

  // Sends an n-word frame on u0; records the cycle of each handshake edge.
  task automatic send0(input logic [31:0] w[3], input int n, input bit chk_lat,
                       input bit keep_valid, output int hs_cyc[3]);
    push_pre(8, 1'b0);
    for (int k = 0; k < n; k++) push_word(w[k], 1'b0);
    q_evt0.push_back(2'b10);
    @(posedge clk32); #1;
    ax0.tdata = w[0]; ax0.tlast = (n == 1); ax0.tvalid = 1'b1;
    if (chk_lat) begin
      @(negedge clk32); chk("u0_start_early", {31'd0, act0}, 0);
      @(negedge clk32); chk("u0_start_latency", {31'd0, act0}, 1);
    end
    for (int k = 0; k < n; k++) begin
      wait_hs0();
      @(posedge clk32); #1;
      hs_cyc[k] = cyc;
      if (k + 1 < n) begin
        ax0.tdata = w[k+1]; ax0.tlast = (k + 1 == n - 1);
      end else if (!keep_valid) begin
        ax0.tvalid = 1'b0; ax0.tlast = 1'b0;
      end
    end
  endtask

  task automatic send1(input logic [31:0] w, input bit chk_lat, input bit keep_valid);
    push_pre(2, 1'b1);
    push_word(w, 1'b1);
    @(posedge clk32); #1;
    ax1.tdata = w; ax1.tlast = 1'b1; ax1.tvalid = 1'b1;
    if (chk_lat) begin
      @(negedge clk32); chk("u1_start_early", {31'd0, act1}, 0);
      @(negedge clk32); chk("u1_start_latency", {31'd0, act1}, 1);
    end
    wait_hs1();
    @(posedge clk32); #1;
    if (!keep_valid) begin ax1.tvalid = 1'b0; ax1.tlast = 1'b0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs[3];
    bit got;
    ax0.tdata = '0; ax0.tvalid = 1'b0; ax0.tlast = 1'b0;
    ax1.tdata = '0; ax1.tvalid = 1'b0; ax1.tlast = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_iq_txd", {30'd0, txd0}, 0);
    chk("rst_tready", {31'd0, ax0.tready}, 0);
    chk("rst_flags", {29'd0, act0, fd0, ur0}, 0);
    repeat (3) @(negedge clk32);
    reset = 1'b0;
    repeat (2) @(negedge clk32);

    // single word, tlast on first word
    send0('{32'h5555_5555, 32'h0, 32'h0}, 1, 1'b1, 1'b0, hs);
    drain0(8);
    chk("single_active_len", last_hi0, 24);

    // three-word frame, tvalid held through the frame
    rdy_cnt0 = 0;
    send0('{32'h0000_FFFF, 32'hFFFF_0000, 32'h5555_5555}, 3, 1'b1, 1'b0, hs);
    drain0(8);
    chk("three_hs_gap_1", hs[1] - hs[0], 16);
    chk("three_hs_gap_2", hs[2] - hs[1], 16);
    chk("three_tready_cnt", rdy_cnt0, 3);
    chk("three_active_len", last_hi0, 56);

    // underrun: word 2 missing at its load point, then drained in FLUSH
    push_pre(8, 1'b0);
    push_word(32'h0F0F_0F0F, 1'b0);
    q_evt0.push_back(2'b01);
    @(posedge clk32); #1;
    ax0.tdata = 32'h0F0F_0F0F; ax0.tlast = 1'b0; ax0.tvalid = 1'b1;
    wait_hs0();
    @(posedge clk32); #1;
    ax0.tvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk32);
      if (ur0) got = 1'b1;
    end
    chk("under_seen", {31'd0, got}, 1);
    chk("under_line_zero", {30'd0, txd0}, 0);
    chk("flush_tready", {31'd0, ax0.tready}, 1);
    ax0.tdata = 32'hDEAD_BEEF; ax0.tlast = 1'b1; ax0.tvalid = 1'b1;
    @(posedge clk32); #1;
    ax0.tvalid = 1'b0; ax0.tlast = 1'b0;
    @(negedge clk32);
    chk("flush_to_gap_tready", {31'd0, ax0.tready}, 0);
    drain0(8);
    chk("under_active_len", last_hi0, 24);

    // back-to-back frames, tvalid continuously high
    send0('{32'h1234_5678, 32'h0, 32'h0}, 1, 1'b1, 1'b1, hs);
    send0('{32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'h0}, 2, 1'b0, 1'b0, hs);
    drain0(8);
    chk("b2b_zero_run", last_lo0, 5);

    // reset two cycles into word 1
    push_pre(8, 1'b0);
    push_word(32'hC3C3_C3C3, 1'b0);
    q_evt0.push_back(2'b10);
    @(posedge clk32); #1;
    ax0.tdata = 32'hC3C3_C3C3; ax0.tlast = 1'b1; ax0.tvalid = 1'b1;
    wait_hs0();
    @(posedge clk32); #1;
    ax0.tvalid = 1'b0; ax0.tlast = 1'b0;
    @(posedge clk32);
    @(posedge clk32); #1;
    chk("pre_rst_active", {31'd0, act0}, 1);
    reset = 1'b1;
    #1;
    chk("arst_iq_txd", {30'd0, txd0}, 0);
    chk("arst_tready", {31'd0, ax0.tready}, 0);
    chk("arst_active", {31'd0, act0}, 0);
    q_sym0.delete();
    q_evt0.delete();
    repeat (2) @(negedge clk32);
    reset = 1'b0;
    repeat (2) @(negedge clk32);
    send0('{32'h8421_8421, 32'h0, 32'h0}, 1, 1'b1, 1'b0, hs);
    drain0(8);
    chk("post_rst_active_len", last_hi0, 24);

    // short preamble / short gap instance, back-to-back
    fd_cnt1 = 0;
    send1(32'hAAAA_AAAA, 1'b1, 1'b1);
    send1(32'h3C3C_3C3C, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk32);
      got = (q_sym1.size() == 0);
    end
    chk("u1_drain", {31'd0, got}, 1);
    repeat (4) @(negedge clk32);
    chk("u1_zero_run", last_lo1, 2);
    chk("u1_active_len", last_hi1, 18);
    chk("u1_frame_done_cnt", fd_cnt1, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
